// File: rtl/nios_project_13_btn_pkg.sv
// Shared constants and helpers for the nios_project_13 push-button conditioning blocks.
package nios_project_13_btn_pkg;

    localparam int BTN_SYNC_STAGES     = 2;
    localparam int BTN_DEBOUNCE_CYCLES = 500000;
    localparam int BTN_HOLD_CYCLES     = 1500000;

    // Bits needed to hold values 0 .. value-1; never less than one bit.
    function automatic int btn_clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/nios_project_13_sync_ff.sv
// N-flop synchronizer for asynchronous PIO inputs; RESET_VALUE is loaded into every stage.
module nios_project_13_sync_ff #(
    parameter int   N           = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic stage_reg [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        stage_reg[gi] <= RESET_VALUE;
                    end else begin
                        stage_reg[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        stage_reg[gi] <= RESET_VALUE;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[N-1];

endmodule

// File: rtl/nios_project_13_btn_debounce.sv
// Push-button conditioner: synchronize, debounce, and strobe press/release (and long-press
// when NIOS_PROJECT_13_BTN_HOLD_EN is defined) for the btn PIO.
module nios_project_13_btn_debounce
    import nios_project_13_btn_pkg::*;
#(
    parameter int SYNC_STAGES     = BTN_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = BTN_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw_n,
    output logic btn_pressed,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int             CNT_W    = btn_clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_raw_n;
    logic             sync_p;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pressed_reg, pressed_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;

    // Chain resets to 1 so a reset reads as "released" on the raw side.
    nios_project_13_sync_ff #(
        .N           (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw_n),
        .q       (sync_raw_n)
    );

    assign sync_p = ~sync_raw_n;

    always_comb begin
        count_next   = count_reg;
        pressed_next = pressed_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (sync_p == pressed_reg) begin
            count_next = '0;
        end else if (count_reg == CNT_LAST) begin
            pressed_next = sync_p;
            count_next   = '0;
            press_next   = sync_p;
            release_next = ~sync_p;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            pressed_reg <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            pressed_reg <= pressed_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    assign btn_pressed = pressed_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

`ifdef NIOS_PROJECT_13_BTN_HOLD_EN
    localparam int              HOLD_W    = btn_clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              hold_strobe_reg, hold_strobe_next;

    // Saturating at HOLD_LAST is what limits btn_hold to one pulse per press.
    always_comb begin
        hold_next        = hold_reg;
        hold_strobe_next = 1'b0;
        if (!pressed_reg) begin
            hold_next = '0;
        end else if (hold_reg != HOLD_LAST) begin
            hold_next = hold_reg + 1'b1;
            if ((hold_next == HOLD_LAST) && !release_next) begin
                hold_strobe_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg        <= '0;
            hold_strobe_reg <= 1'b0;
        end else begin
            hold_reg        <= hold_next;
            hold_strobe_reg <= hold_strobe_next;
        end
    end

    assign btn_hold = hold_strobe_reg;
`else
    // Always 0; the parameter is still referenced so the interface stays identical.
    assign btn_hold = 1'b0 & (HOLD_CYCLES < 0);
`endif

endmodule
